// File: rtl/qspi_tx_sequencer.sv
// qspi_tx_sequencer
//   Write data phase of a QSPI command. Pops 32-bit words from the write
//   sync FIFO (registered read port) and shifts them out MSB-first on 1, 2
//   or 4 IO lanes. Each shift_tick advances one bit-group.
// Ports
//   clk, rst_n          clock, async active-low reset
//   start, byte_len,    begin a transfer (IDLE only); length and lane mode
//   lane_mode           are captured with start
//   abort               return to IDLE from any state, no done
//   shift_tick          advance one bit-group while shifting
//   fifo_rd_en/_data/   FIFO read port (data valid the cycle after rd_en)
//   fifo_empty
//   io_out, io_oe       lane data / output enables
//   busy, stall, done   status: not idle / starved by FIFO / completion pulse
module qspi_tx_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  byte_len,
  input  logic [1:0]            lane_mode,
  input  logic                  abort,
  input  logic                  shift_tick,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty,
  output logic [3:0]            io_out,
  output logic [3:0]            io_oe,
  output logic                  busy,
  output logic                  stall,
  output logic                  done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_LOAD, S_SHIFT, S_DONE
  } state_e;

  // mode_q encoding: 0 single, 1 dual, 2 quad (lane_mode 11 folds to single)
  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  bytes_left_q, bytes_left_d;
  logic [5:0]            word_bits_q, word_bits_d;
  logic [1:0]            mode_q, mode_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;

  logic [5:0] grp;
  logic [2:0] take;

  always_comb begin
    case (mode_q)
      2'd2:    grp = 6'd4;
      2'd1:    grp = 6'd2;
      default: grp = 6'd1;
    endcase
  end

  // bytes carried by the word being loaded; a short final word keeps only
  // its upper bytes because shifting stops after word_bits
  assign take = (bytes_left_q >= LEN_WIDTH'(4)) ? 3'd4 : bytes_left_q[2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bytes_left_q <= '0;
      word_bits_q  <= '0;
      mode_q       <= '0;
      sr_q         <= '0;
    end else begin
      state_q      <= state_d;
      bytes_left_q <= bytes_left_d;
      word_bits_q  <= word_bits_d;
      mode_q       <= mode_d;
      sr_q         <= sr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bytes_left_d = bytes_left_q;
    word_bits_d  = word_bits_q;
    mode_d       = mode_q;
    sr_d         = sr_q;
    fifo_rd_en   = 1'b0;
    stall        = 1'b0;
    done         = 1'b0;
    io_out       = 4'b0000;
    io_oe        = 4'b0000;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (byte_len != '0) begin
            state_d      = S_FETCH;
            bytes_left_d = byte_len;
            mode_d       = (lane_mode == 2'b11) ? 2'd0 : lane_mode;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_FETCH: begin
        if (fifo_empty) begin
          stall = 1'b1;
        end else begin
          fifo_rd_en = 1'b1;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: state_d = S_LOAD;
      S_LOAD: begin
        sr_d         = fifo_rd_data;
        word_bits_d  = {take, 3'b000};
        bytes_left_d = bytes_left_q - LEN_WIDTH'(take);
        state_d      = S_SHIFT;
      end
      S_SHIFT: begin
        case (mode_q)
          2'd2: begin
            io_out = sr_q[DATA_WIDTH-1 -: 4];
            io_oe  = 4'b1111;
          end
          2'd1: begin
            io_out = {2'b00, sr_q[DATA_WIDTH-1 -: 2]};
            io_oe  = 4'b0011;
          end
          default: begin
            io_out = {3'b000, sr_q[DATA_WIDTH-1]};
            io_oe  = 4'b0001;
          end
        endcase
        if (shift_tick) begin
          sr_d        = sr_q << grp;
          word_bits_d = word_bits_q - grp;
          if (word_bits_q == grp)
            state_d = (bytes_left_q != '0) ? S_FETCH : S_DONE;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // abort wins over everything; suppressing the pop here means no word is
    // left in flight, while a pop issued the cycle before is simply dropped
    if (abort) begin
      state_d    = S_IDLE;
      fifo_rd_en = 1'b0;
      done       = 1'b0;
    end
  end

  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_qspi_tx_sequencer.sv
// Scoreboard bench for qspi_tx_sequencer: a FIFO model feeds words, a
// bit-stream reference model queues the expected lane groups and the done
// marker, and a negedge monitor pops/compares whenever the DUT shifts a
// group or pulses done.
module tb_qspi_tx_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] byte_len = '0;
  logic [1:0]  lane_mode = '0;
  logic        abort = 1'b0;
  logic        shift_tick = 1'b0;
  logic        fifo_rd_en;
  logic [31:0] fifo_rd_data = '0;
  logic        fifo_empty;
  logic [3:0]  io_out, io_oe;
  logic        busy, stall, done;

  qspi_tx_sequencer #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_len(byte_len),
    .lane_mode(lane_mode), .abort(abort), .shift_tick(shift_tick),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .io_out(io_out), .io_oe(io_oe),
    .busy(busy), .stall(stall), .done(done)
  );

  always #5 clk = ~clk;

  // FIFO model: pushes written by stimulus only, pops by the read port only
  logic [31:0] fmem [0:1023];
  int pushes = 0;
  int pops = 0;
  assign fifo_empty = (pushes == pops);
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= fmem[pops];
      pops         <= pops + 1;
    end
  end

  typedef struct {
    bit         is_done;
    logic [3:0] io;
    logic [3:0] oe;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor
  logic prev_rd = 1'b0;
  int   stall_cnt = 0;
  exp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (io_oe != 4'b0000 && shift_tick) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_shift: got io=%0h with nothing expected", io_out);
        end else begin
          e = sb.pop_front();
          chk("shift_kind", {31'd0, e.is_done}, 32'd0);
          chk("io_out", {28'd0, io_out}, {28'd0, e.io});
          chk("io_oe", {28'd0, io_oe}, {28'd0, e.oe});
        end
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: got done=1 with nothing expected");
        end else begin
          e = sb.pop_front();
          chk("done_kind", {31'd0, e.is_done}, 32'd1);
        end
      end
      if (fifo_rd_en) begin
        chk("rd_en_while_empty", {31'd0, fifo_empty}, 32'd0);
        chk("rd_en_back_to_back", {31'd0, prev_rd}, 32'd0);
      end
      if (stall) stall_cnt <= stall_cnt + 1;
      prev_rd <= fifo_rd_en;
    end else begin
      prev_rd <= 1'b0;
    end
  end

  task automatic push_word(logic [31:0] w);
    fmem[pushes] = w;
    pushes++;
  endtask

  // reference: the transfer is the first len*8 bits of the word stream,
  // MSB of each word first, cut into G-bit groups
  task automatic build_expect(int len, int lm, int base);
    int g;
    logic [3:0] val;
    logic [31:0] w;
    g = (lm == 2) ? 4 : (lm == 1) ? 2 : 1;
    for (int k = 0; k < len * 8; k += g) begin
      val = 4'd0;
      for (int b = 0; b < g; b++) begin
        w   = fmem[base + (k + b) / 32];
        val = {val[2:0], w[31 - ((k + b) % 32)]};
      end
      sb.push_back('{is_done: 1'b0, io: val, oe: 4'((1 << g) - 1)});
    end
    sb.push_back('{is_done: 1'b1, io: 4'd0, oe: 4'd0});
  endtask

  // one transfer; late>0 holds back the last new word until that cycle,
  // abort_at/rst_at >=0 interrupt the transfer at that cycle
  task automatic xfer(int len, int lm, int pct, int late, int abort_at, int rst_at);
    int nw, have, need, p0, cyc, last_tick;
    bit seen, late_pend;
    nw   = (len + 3) / 4;
    have = pushes - pops;
    need = (nw > have) ? nw - have : 0;
    for (int i = 0; i < need; i++) fmem[pushes + i] = $urandom;
    late_pend = (late > 0) && (need > 0);
    pushes += late_pend ? need - 1 : need;
    p0 = pops;
    build_expect(len, lm, p0);
    @(posedge clk); #1;
    start = 1'b1; byte_len = 16'(len); lane_mode = 2'(lm);
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; seen = 0; last_tick = -10;
    while (!seen && cyc < 2000) begin
      shift_tick = ($urandom_range(99) < pct);
      if (late_pend && cyc == late) begin
        pushes++;
        late_pend = 0;
      end
      if (cyc == abort_at) begin
        abort = 1'b1; shift_tick = 1'b0;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_oe", {28'd0, io_oe}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        chk("abort_no_done_idle", {30'd0, busy, done}, 32'd0);
        return;
      end
      if (cyc == rst_at) begin
        rst_n = 1'b0; shift_tick = 1'b0;
        #1;
        chk("rst_outs", {20'd0, io_out, io_oe, fifo_rd_en, busy, stall, done},
            32'd0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      @(negedge clk);
      if (len == 0) chk("zero_len_oe", {28'd0, io_oe}, 32'd0);
      if (io_oe != 4'b0000 && shift_tick) last_tick = cyc;
      if (done) seen = 1;
      @(posedge clk); #1;
      if (!seen) cyc++;
    end
    shift_tick = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    if (len == 0) chk("zero_len_done_cycle", cyc, 0);
    else          chk("done_after_last_tick", cyc - last_tick, 1);
    chk("pop_count", pops - p0, nw);
    chk("sb_drained", sb.size(), 0);
    chk("idle_after", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int s0;
    #12;
    chk("reset_outs", {20'd0, io_out, io_oe, fifo_rd_en, busy, stall, done},
        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // quad, two full words, tick every cycle
    push_word(32'hA1B2C3D4);
    push_word(32'h11223344);
    xfer(8, 2, 100, 0, -1, -1);

    // single, 3 bytes: low byte of the word is never shifted
    push_word(32'h80FF01AA);
    xfer(3, 0, 100, 0, -1, -1);

    // dual with the second word arriving late
    push_word(32'h5A5AC3C3);
    s0 = stall_cnt;
    xfer(8, 1, 100, 28, -1, -1);
    chk("stall_seen", (stall_cnt - s0 >= 5) ? 1 : 0, 1);

    // zero length
    xfer(0, 2, 100, 0, -1, -1);

    // abort mid-shift of a 16-byte quad transfer, then a normal transfer
    for (int i = 0; i < 4; i++) push_word($urandom);
    xfer(16, 2, 100, 0, 10, -1);
    xfer(4, 2, 100, 0, -1, -1);

    // reset mid-shift, then a normal transfer
    xfer(8, 0, 100, 0, -1, 6);
    xfer(5, 1, 60, 0, -1, -1);

    // randomized transfers (mode 3 folds to single)
    for (int t = 0; t < 24; t++)
      xfer($urandom_range(20), $urandom_range(3), $urandom_range(100, 25),
           ($urandom_range(3) == 0) ? $urandom_range(60, 5) : 0, -1, -1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
